fifo_drain_ctrl: RTL
====================

// Module: fifo_drain_ctrl
// PURPOSE
//   Read-side engine for synchronous_fifo. Pops words from the FIFO and
//   delivers them in order on a valid/ready output stream.
//   Absorbs the FIFO's 1-cycle read latency and downstream backpressure
//   in a 2-entry output buffer. Sits between the FIFO read port and the
//   consumer.
// PARAMETERS
//   DATA_WIDTH  8   width of FIFO data_out and m_data
//   CNT_WIDTH   16  width of drain_count
// PORTS
//   clk             in   1           single clock, rising edge
//   rst             in   1           asynchronous, active-high reset
//   enable          in   1           1 = new FIFO reads allowed
//   fifo_empty      in   1           FIFO empty flag
//   fifo_rd_en      out  1           FIFO read strobe (to r_en)
//   fifo_data_out   in   DATA_WIDTH  FIFO data_out, valid the cycle after rd_en
//   m_valid         out  1           output word valid
//   m_ready         in   1           consumer accepts word
//   m_data          out  DATA_WIDTH  output word
//   drain_count     out  CNT_WIDTH   words delivered since reset
//   idle            out  1           no word buffered or in flight
// BEHAVIOUR
//   Reset (rst=1, async): m_valid=0, fifo_rd_en=0, m_data=0, drain_count=0,
//     idle=1. Buffer and in-flight flag are cleared. A mid-operation reset
//     discards buffered and in-flight words.
//   State:
//     buf_cnt (0..2): 2-entry FIFO-ordered buffer; head drives m_data.
//     inflight: fifo_rd_en registered.
//     occ = buf_cnt + inflight (0..2).
//   pop = m_valid & m_ready; m_valid = (buf_cnt != 0).
//   fifo_rd_en is combinational:
//     = enable & ~fifo_empty & ~rst & ((occ < 2) | pop)
//   fifo_rd_en is never asserted while fifo_empty=1.
//   Capture: when inflight=1, fifo_data_out is written to the buffer tail on
//     the next rising edge. Tail index accounts for a same-edge pop.
//   Latency: rd_en in cycle N -> data on fifo_data_out in N+1 ->
//     m_valid in N+2 (buffer previously empty).
//   Throughput: 1 word/cycle sustained when m_ready=1 and FIFO not empty.
//   Handshake:
//     - While m_valid=1 & m_ready=0, m_data holds stable and m_valid stays 1.
//     - Order is strictly preserved; no word is dropped or duplicated.
//   Simultaneous capture and pop: head advances and the new word is enqueued
//     on the same edge; buf_cnt is unchanged.
//   Overflow: occ never exceeds 2, so a capture never overflows the buffer.
//   enable=0: no new rd_en from the same cycle. An in-flight word is still
//     captured and delivered.
//   drain_count: +1 on each pop; wraps 2^CNT_WIDTH-1 -> 0.
//   idle = (occ == 0).
// TESTING
//   1. Assert rst mid-cycle -> outputs go immediately to m_valid=0,
//      fifo_rd_en=0, drain_count=0, idle=1.
//   2. Write 0x11,0x22,0x33 into the FIFO; enable=1, m_ready=1 ->
//      first m_valid 2 cycles after the first rd_en; m_data 0x11,0x22,0x33
//      on consecutive cycles; drain_count=3; idle=1 afterwards.
//   3. Write 0x00..0x07 with m_ready=0 -> exactly 2 rd_en pulses;
//      m_data holds 0x00. Release m_ready -> 0x00..0x07 in order, no gaps
//      after the first; drain_count=8.
//   4. FIFO empty with enable=1 for 20 cycles -> fifo_rd_en stays 0;
//      m_valid stays 0; idle stays 1.
//   5. 8 words streaming, drop enable right after the 3rd rd_en ->
//      exactly 3 words are delivered and no further rd_en.
//      Re-enable -> remaining 0x03..0x07 are delivered.
//   6. Toggle m_ready every cycle over 8 words -> every accepted word
//      matches the FIFO write order; no loss or duplication; drain_count=8.

Source files
------------

// File: rtl/fifo_drain_ctrl.sv
// Read-side engine: pops a synchronous FIFO, absorbs its 1-cycle read latency
// and downstream backpressure in a 2-entry buffer, streams words out valid/ready.
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  drain_count,
  output logic                  idle
);

  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic [1:0]            buf_cnt;
  logic                  inflight;
  logic [1:0]            occ;
  logic                  pop;

  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = buf0;
  assign pop     = m_valid & m_ready;
  assign occ     = buf_cnt + {1'b0, inflight};
  assign idle    = (occ == 2'd0);

  // A read may be issued when a slot is free now, or one frees on this edge.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (enable && !fifo_empty && !rst && ((occ < 2'd2) || pop))
      fifo_rd_en = 1'b1;
  end

  // Buffer, in-flight flag and delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0        <= '0;
      buf1        <= '0;
      buf_cnt     <= 2'd0;
      inflight    <= 1'b0;
      drain_count <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop)
        drain_count <= drain_count + 1'b1;
      // Tail slot depends on whether the head leaves on this same edge.
      case ({inflight, pop})
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf0 <= fifo_data_out;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_data_out;
          end
        end
        2'b10: begin
          if (buf_cnt == 2'd0)
            buf0 <= fifo_data_out;
          else
            buf1 <= fifo_data_out;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
